// File: rtl/spi_pkg.sv
// Shared SPI-path types: transfer mode, ADS1256 sequencer states and command bytes.
package spi_pkg;

  typedef enum logic [1:0] {
    SPI_TX_ONLY = 2'd0,
    SPI_RX_ONLY = 2'd1,
    SPI_TX_RX   = 2'd2
  } spi_mode_t;

  typedef enum logic [2:0] {
    ADS_IDLE,
    ADS_WAIT_DRDY,
    ADS_SEND_CMD,
    ADS_WAIT_CMD,
    ADS_T6,
    ADS_READ,
    ADS_WAIT_BYTE,
    ADS_DONE
  } ads_state_t;

  localparam logic [7:0] ADS_CMD_RDATA  = 8'h01;
  localparam logic [7:0] ADS_CMD_SDATAC = 8'h0F;
  localparam logic [7:0] ADS_DUMMY      = 8'h00;

endpackage

// File: rtl/ads1256_reader_if.sv
// Byte-level handshake between the ADS1256 command sequencer (master) and the SPI core (slave).
interface ads1256_reader_if;
  import spi_pkg::*;

  logic       spi_start_o;
  logic [7:0] spi_tx_buffer_o;
  spi_mode_t  spi_mode_o;
  logic [7:0] spi_rx_buffer_i;
  logic       spi_done_i;

  modport master (
    output spi_start_o, spi_tx_buffer_o, spi_mode_o,
    input  spi_rx_buffer_i, spi_done_i
  );

  modport slave (
    input  spi_start_o, spi_tx_buffer_o, spi_mode_o,
    output spi_rx_buffer_i, spi_done_i
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs, with a selectable reset value.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state always uses non-blocking assignments so both flops sample the old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ads1256_reader.sv
// ADS1256 RDATA sequencer: waits for DRDY, reads 3 bytes through the SPI core, emits a 24-bit sample.
// Optional DRDY watchdog enabled by defining ADS1256_DRDY_TIMEOUT_EN (adds timeout_o).
module ads1256_reader
  import spi_pkg::*;
#(
  parameter int T6_CYCLES      = 651
`ifdef ADS1256_DRDY_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 10_000_000
`endif
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic                    continuous_i,
  input  logic                    drdy_i,
  ads1256_reader_if.master        spi,
  output logic [23:0]             sample_o,
  output logic                    sample_valid_o,
  output logic [15:0]             sample_count_o,
  output logic                    busy_o
`ifdef ADS1256_DRDY_TIMEOUT_EN
  , output logic                  timeout_o
`endif
);

  localparam int T6_W = $clog2(T6_CYCLES + 1);

  ads_state_t      state;
  logic            drdy_s;
  logic            done_q;
  logic            done_edge;
  logic            spi_start;
  logic [7:0]      spi_tx;
  logic [T6_W-1:0] t6_cnt;
  logic [1:0]      byte_idx;
  logic [15:0]     shreg;

`ifdef ADS1256_DRDY_TIMEOUT_EN
  logic [23:0]     to_cnt;
`endif

  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_drdy_sync (
    .clk   (clock_i),
    .rst_n (reset_i),
    .d     (drdy_i),
    .q     (drdy_s)
  );

  // Rising-edge detect accepts both pulse-style and level-style done from the SPI core.
  assign done_edge = spi.spi_done_i & ~done_q;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state          <= ADS_IDLE;
      done_q         <= 1'b0;
      spi_start      <= 1'b0;
      spi_tx         <= ADS_DUMMY;
      t6_cnt         <= '0;
      byte_idx       <= 2'd0;
      shreg          <= '0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      sample_count_o <= '0;
      busy_o         <= 1'b0;
`ifdef ADS1256_DRDY_TIMEOUT_EN
      to_cnt         <= '0;
      timeout_o      <= 1'b0;
`endif
    end else begin
      done_q         <= spi.spi_done_i;
      spi_start      <= 1'b0;
      sample_valid_o <= 1'b0;
`ifdef ADS1256_DRDY_TIMEOUT_EN
      to_cnt <= (state == ADS_WAIT_DRDY && drdy_s) ? to_cnt + 24'd1 : '0;
`endif
      unique case (state)
        ADS_IDLE: if (start_i) begin
          state  <= ADS_WAIT_DRDY;
          busy_o <= 1'b1;
`ifdef ADS1256_DRDY_TIMEOUT_EN
          timeout_o <= 1'b0;
`endif
        end
        ADS_WAIT_DRDY: begin
          if (!drdy_s) begin
            state <= ADS_SEND_CMD;
          end
`ifdef ADS1256_DRDY_TIMEOUT_EN
          else if (to_cnt == 24'(TIMEOUT_CYCLES - 1)) begin
            state     <= ADS_IDLE;
            busy_o    <= 1'b0;
            timeout_o <= 1'b1;
          end
`endif
        end
        ADS_SEND_CMD: begin
          spi_start <= 1'b1;
          spi_tx    <= ADS_CMD_RDATA;
          state     <= ADS_WAIT_CMD;
        end
        ADS_WAIT_CMD: if (done_edge) begin
          t6_cnt <= T6_W'(T6_CYCLES - 1);
          state  <= ADS_T6;
        end
        ADS_T6: begin
          if (t6_cnt == '0) begin
            byte_idx <= 2'd2;
            state    <= ADS_READ;
          end else begin
            t6_cnt <= t6_cnt - 1'b1;
          end
        end
        ADS_READ: begin
          spi_start <= 1'b1;
          spi_tx    <= ADS_DUMMY;
          state     <= ADS_WAIT_BYTE;
        end
        ADS_WAIT_BYTE: if (done_edge) begin
          // Final byte goes straight into the sample so valid trails the done edge by one cycle.
          if (byte_idx == 2'd0) begin
            sample_o       <= {shreg, spi.spi_rx_buffer_i};
            sample_valid_o <= 1'b1;
            sample_count_o <= sample_count_o + 16'd1;
            state          <= ADS_DONE;
          end else begin
            shreg    <= {shreg[7:0], spi.spi_rx_buffer_i};
            byte_idx <= byte_idx - 2'd1;
            state    <= ADS_READ;
          end
        end
        ADS_DONE: begin
          if (continuous_i) begin
            state <= ADS_WAIT_DRDY;
          end else begin
            state  <= ADS_IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= ADS_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  assign spi.spi_start_o     = spi_start;
  assign spi.spi_tx_buffer_o = spi_tx;
  assign spi.spi_mode_o      = SPI_TX_RX;

endmodule

// File: doc/ads1256_reader.md
Name: ads1256_reader

Overview:
- Command sequencer that sits directly upstream of the `spi` core on the ADS1256 PMOD path.
- Waits for the ADC's DRDY to fall, then issues RDATA (01h) through the SPI core.
- Honours the ADS1256 t6 command-to-data delay, then clocks out 3 data bytes.
- Assembles the bytes into a 24-bit two's-complement sample with a valid pulse for downstream logic; replaces the hardcoded tx_buffer/start wiring at chip level.

Parameters:
- T6_CYCLES, 651, clock_i cycles between the RDATA byte completing and the first read byte starting (50 tCLKIN at 7.68 MHz, 100 MHz clock).
- TIMEOUT_CYCLES, 10_000_000, maximum clock_i cycles spent waiting for DRDY low (used only with the optional feature).

Ports:
- clock_i  input  1  system clock, 100 MHz.
- reset_i  input  1  asynchronous, active-low reset.
- start_i  input  1  level; sampled in IDLE, begins an acquisition.
- continuous_i  input  1  1 = re-arm after each sample; 0 = single shot.
- drdy_i  input  1  raw ADS1256 DRDY, active-low, asynchronous to clock_i.
- spi_start_o  output  1  one-cycle pulse that launches one SPI byte transfer.
- spi_tx_buffer_o  output  8  byte to transmit.
- spi_mode_o  output  spi_mode_t  always SPI_TX_RX.
- spi_rx_buffer_i  input  8  byte received by the SPI core.
- spi_done_i  input  1  SPI core transfer-complete indication.
- sample_o  output  24  last assembled sample, MSB first, two's complement.
- sample_valid_o  output  1  one-cycle pulse when sample_o updates.
- sample_count_o  output  16  samples produced since reset; wraps FFFFh -> 0000h.
- busy_o  output  1  high in every state except IDLE.

Behaviour:
- Reset values: spi_start_o=0, spi_tx_buffer_o=00h, sample_o=0, sample_valid_o=0, sample_count_o=0, busy_o=0; state=IDLE. Reset is legal mid-transfer: every output returns to its reset value immediately, and the FSM does not wait for the SPI core.
- drdy_i passes through a 2-flop synchroniser (reset value 1); the FSM uses only the synchronised value.
- spi_done_i is edge-detected (0->1) so both pulse-style and level-style done signals are accepted. A done rising edge is honoured only in a WAIT_* state; it is ignored everywhere else.
- FSM states:
  - IDLE: busy_o=0. If start_i=1 -> WAIT_DRDY.
  - WAIT_DRDY: on synchronised DRDY=0 -> SEND_CMD.
  - SEND_CMD: drive spi_tx_buffer_o=01h and spi_start_o=1 for exactly one cycle -> WAIT_CMD.
  - WAIT_CMD: on done edge -> T6, counter loaded with T6_CYCLES-1.
  - T6: count down to 0 -> READ (byte index=2).
  - READ: drive spi_tx_buffer_o=00h and spi_start_o=1 for one cycle -> WAIT_BYTE.
  - WAIT_BYTE: on done edge, latch spi_rx_buffer_i into shift register byte[index]. If index=0 -> DONE; else decrement index -> READ.
  - DONE: sample_o <= {byte2, byte1, byte0}; sample_valid_o=1 for this cycle; sample_count_o += 1. If continuous_i=1 -> WAIT_DRDY, else -> IDLE.
- Latency:
  - DRDY sync to SEND_CMD: 3 cycles after drdy_i falls.
  - sample_valid_o: 1 cycle after the third byte's done edge.
- continuous_i is sampled only in DONE, so clearing it mid-conversion finishes the current sample.
- start_i has no effect outside IDLE.
- sample_o holds its value between updates.
- DRDY rising mid-read is ignored: data is already latched in the ADC.

Optional Feature:
- Macro: ADS1256_DRDY_TIMEOUT_EN.
- Enabled:
  - Adds output timeout_o (1 bit, reset 0).
  - A 24-bit counter runs in WAIT_DRDY and clears on exit from that state.
  - Reaching TIMEOUT_CYCLES -> state IDLE and timeout_o=1 (sticky), cleared by the next start_i accepted in IDLE.
- Disabled: no counter and no port; WAIT_DRDY waits indefinitely.

Decomposition:
- Shared package (spi_pkg, which already holds spi_mode_t) gains:
  - ads_state_t enum;
  - ADS_CMD_RDATA=8'h01;
  - ADS_CMD_SDATAC=8'h0F;
  - ADS_DUMMY=8'h00.
- One sub-module, sync_2ff (generic 2-flop synchroniser with parameterised reset value), used for drdy_i.

Test Plan:
- Single shot: start_i=1, continuous_i=0, drdy_i falls, SPI model returns 12h,34h,56h -> exactly 4 spi_start_o pulses (tx 01h,00h,00h,00h); sample_o=123456h; one sample_valid_o pulse; sample_count_o=1; busy_o=0 afterwards.
- t6 timing: measure from the RDATA done edge to the 2nd spi_start_o -> exactly T6_CYCLES+1 cycles (652 with default).
- Continuous: continuous_i=1, 3 DRDY pulses, bytes FFh,FFh,FEh each time -> sample_o=FFFFFEh (-2); sample_count_o=3; FSM back in WAIT_DRDY. Then clear continuous_i mid-read -> that sample completes, then IDLE.
- Reset mid-read: assert reset_i low during WAIT_BYTE of byte 1 -> all outputs at reset values asynchronously; after release, no spi_start_o until start_i=1 and DRDY low.
- Spurious done: pulse spi_done_i during IDLE and T6 -> no state change, no byte latched.
- Timeout (ADS1256_DRDY_TIMEOUT_EN, TIMEOUT_CYCLES=100): start_i=1 with drdy_i held high -> timeout_o=1 after 100 cycles, busy_o=0; next start_i clears timeout_o.
